// File: rtl/ps2_num_entry.sv
// Decimal operand entry from the PS/2 key stream: accumulates digits as binary and BCD,
// then hands the committed operand to the calculator over valid/ready.
module ps2_num_entry #(
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned WIDTH      = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  input  logic [7:0]              key_ascii,
  output logic [WIDTH-1:0]        num_bin,
  output logic                    num_valid,
  input  logic                    num_ready,
  output logic [4*MAX_DIGITS-1:0] entry_bcd,
  output logic [3:0]              digit_cnt,
  output logic                    overflow_err,
  output logic                    key_dropped
);

  localparam int unsigned BW = 4 * MAX_DIGITS;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    HOLD
  } state_t;

  state_t           state, state_d;
  logic             key_pend;
  logic             take_key;
  logic             is_digit, is_enter;
  logic [3:0]       digit;
  logic [WIDTH-1:0] acc, acc_d, acc_x10;
  logic [BW-1:0]    bcd_d;
  logic [3:0]       cnt_d;
  logic             ovf_d;
  logic [WIDTH-1:0] num_bin_d;
  logic             num_valid_d;
  logic             dropped_d;

  // A back-to-back key_valid keeps key_pend set and defers processing to the later key.
  assign take_key = key_pend & ~key_valid;
  assign is_digit = take_key && (key_ascii >= 8'h30) && (key_ascii <= 8'h39);
  assign is_enter = take_key && (key_ascii == 8'h0A);
  assign digit    = key_ascii[3:0];
  assign acc_x10  = (acc << 3) + (acc << 1) + WIDTH'(digit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_pend <= 1'b0;
      state    <= IDLE;
    end else begin
      key_pend <= key_valid;
      state    <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc          <= '0;
      entry_bcd    <= '0;
      digit_cnt    <= '0;
      overflow_err <= 1'b0;
      num_bin      <= '0;
      num_valid    <= 1'b0;
      key_dropped  <= 1'b0;
    end else begin
      acc          <= acc_d;
      entry_bcd    <= bcd_d;
      digit_cnt    <= cnt_d;
      overflow_err <= ovf_d;
      num_bin      <= num_bin_d;
      num_valid    <= num_valid_d;
      key_dropped  <= dropped_d;
    end
  end

  always_comb begin
    state_d     = state;
    acc_d       = acc;
    bcd_d       = entry_bcd;
    cnt_d       = digit_cnt;
    ovf_d       = overflow_err;
    num_bin_d   = num_bin;
    num_valid_d = num_valid;
    dropped_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (is_digit) begin
          acc_d   = WIDTH'(digit);
          bcd_d   = BW'(digit);
          cnt_d   = 4'd1;
          state_d = ENTRY;
        end
      end
      ENTRY: begin
        if (is_digit) begin
          if (digit_cnt < 4'(MAX_DIGITS)) begin
            acc_d = acc_x10;
            bcd_d = (entry_bcd << 4) | BW'(digit);
            cnt_d = digit_cnt + 4'd1;
          end else begin
            ovf_d = 1'b1;
          end
        end else if (is_enter) begin
          num_bin_d   = acc;
          num_valid_d = 1'b1;
          state_d     = HOLD;
        end
      end
      HOLD: begin
        if (is_digit || is_enter) dropped_d = 1'b1;
        if (num_valid && num_ready) begin
          acc_d       = '0;
          bcd_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
          num_bin_d   = '0;
          num_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
